// File: rtl/eth_spi_pkg.sv
// Shared types and defaults for the Ethernet-chip SPI scheduler.
// Lane 0 is the DSP lane, lane 1 the FPGA-internal lane.
package eth_spi_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_SHIFT = 3'd2;
    localparam state_t ST_HOLD  = 3'd3;
    localparam state_t ST_GAP   = 3'd4;

    localparam logic LANE_DSP  = 1'b0;
    localparam logic LANE_FPGA = 1'b1;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_CS_SETUP = 2;
    localparam int DEF_CS_HOLD  = 2;
    localparam int DEF_CS_GAP   = 4;

endpackage

// File: rtl/eth_spi_arb.sv
// Two-lane request arbiter for eth_spi_sched.
// ETH_SPI_RR_EN selects round-robin; otherwise lane 0 has fixed priority.
module eth_spi_arb
    import eth_spi_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic fin,
    input  logic fin_lane,
    output logic any,
    output logic win
);

    assign any = req0 | req1;

`ifdef ETH_SPI_RR_EN
    logic ptr;

    // The lane that just finished yields the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= LANE_DSP;
        end else if (fin) begin
            ptr <= ~fin_lane;
        end
    end

    always_comb begin
        win = LANE_DSP;
        if (req0 && req1) begin
            win = ptr;
        end else if (req1) begin
            win = LANE_FPGA;
        end
    end
`else
    logic unused;
    assign unused = ^{clk, rst, fin, fin_lane};

    always_comb begin
        win = LANE_DSP;
        if (!req0 && req1) begin
            win = LANE_FPGA;
        end
    end
`endif

endmodule

// File: rtl/eth_spi_sched.sv
// Two-lane SPI master scheduler for an Ethernet chip (mode 0, MSB first).
// Define ETH_SPI_RR_EN for round-robin arbitration; default is fixed priority.
module eth_spi_sched
    import eth_spi_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int CS_SETUP = DEF_CS_SETUP,
    parameter int CS_HOLD  = DEF_CS_HOLD,
    parameter int CS_GAP   = DEF_CS_GAP
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    input  logic [7:0] tx0_data,
    input  logic [7:0] tx1_data,
    output logic       tx0_rd,
    output logic       tx1_rd,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_id,
    output logic       sck,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
);

    state_t     state;
    logic [7:0] tmr;
    logic [3:0] bcnt;
    logic [2:0] bitn;
    logic       own;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;
    logic       any;
    logic       win;
    logic       rd;
    logic       hold_exit;
    logic [7:0] tx_cur;

    assign rd        = tx0_rd | tx1_rd;
    assign tx_cur    = own ? tx1_data : tx0_data;
    assign hold_exit = (state == ST_HOLD) && (tmr == 8'd0);

    eth_spi_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .fin      (hold_exit),
        .fin_lane (own),
        .any      (any),
        .win      (win)
    );

    // The byte being fetched drives mosi directly during its rd cycle.
    always_comb begin
        mosi = 1'b0;
        if (state == ST_SETUP || state == ST_SHIFT) begin
            mosi = rd ? tx_cur[7] : tx_sh[7];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tmr      <= 8'd0;
            bcnt     <= 4'd0;
            bitn     <= 3'd0;
            own      <= LANE_DSP;
            tx_sh    <= 8'd0;
            rx_sh    <= 8'd0;
            sck      <= 1'b0;
            cs_n     <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            tx0_rd   <= 1'b0;
            tx1_rd   <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            rx_id    <= 1'b0;
        end else begin
            tx0_rd   <= 1'b0;
            tx1_rd   <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            rx_valid <= 1'b0;
            if (rd) begin
                tx_sh <= tx_cur;
            end
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        state  <= ST_SETUP;
                        tmr    <= 8'(CS_SETUP - 1);
                        cs_n   <= 1'b0;
                        own    <= win;
                        gnt0   <= (win == LANE_DSP);
                        gnt1   <= (win == LANE_FPGA);
                        tx0_rd <= (win == LANE_DSP);
                        tx1_rd <= (win == LANE_FPGA);
                        bcnt   <= win ? len1 : len0;
                    end
                end
                ST_SETUP: begin
                    if (tmr == 8'd0) begin
                        state <= ST_SHIFT;
                        tmr   <= 8'(CLK_DIV - 1);
                        bitn  <= 3'd7;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (tmr != 8'd0) begin
                        tmr <= tmr - 8'd1;
                    end else begin
                        tmr <= 8'(CLK_DIV - 1);
                        if (!sck) begin
                            sck   <= 1'b1;
                            rx_sh <= {rx_sh[6:0], miso};
                        end else begin
                            sck <= 1'b0;
                            if (bitn != 3'd0) begin
                                bitn  <= bitn - 3'd1;
                                tx_sh <= {tx_sh[6:0], 1'b0};
                            end else begin
                                rx_data  <= rx_sh;
                                rx_valid <= 1'b1;
                                rx_id    <= own;
                                // Next byte starts its low phase right away.
                                if (bcnt != 4'd0) begin
                                    bcnt   <= bcnt - 4'd1;
                                    bitn   <= 3'd7;
                                    tx0_rd <= (own == LANE_DSP);
                                    tx1_rd <= (own == LANE_FPGA);
                                end else begin
                                    state <= ST_HOLD;
                                    tmr   <= 8'(CS_HOLD - 1);
                                end
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (tmr == 8'd0) begin
                        state <= ST_GAP;
                        tmr   <= 8'(CS_GAP - 1);
                        cs_n  <= 1'b1;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        done0 <= (own == LANE_DSP);
                        done1 <= (own == LANE_FPGA);
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                ST_GAP: begin
                    if (tmr == 8'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_spi_sched.sv
// Bench for eth_spi_sched: vector table, corner sequences and random
// transactions checked against a transaction-level expectation.
module tb_eth_spi_sched;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_GAP   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [3:0] len0 = 4'd0;
    logic [3:0] len1 = 4'd0;
    logic [7:0] tx0_data;
    logic [7:0] tx1_data;
    logic       tx0_rd, tx1_rd, gnt0, gnt1, done0, done1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_id, sck, cs_n, mosi, miso;

    logic [7:0] txa0 [16];
    logic [7:0] txa1 [16];
    logic [7:0] mba  [16];
    logic [3:0] i0 = 4'd0;
    logic [3:0] i1 = 4'd0;
    logic [3:0] mi = 4'd0;
    logic       lpbk = 1'b0;
    logic       sl_bit = 1'b0;

    assign tx0_data = txa0[i0];
    assign tx1_data = txa1[i1];
    assign miso     = lpbk ? mosi : sl_bit;

    eth_spi_sched #(
        .CLK_DIV  (CLK_DIV),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD),
        .CS_GAP   (CS_GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .len0     (len0),
        .len1     (len1),
        .tx0_data (tx0_data),
        .tx1_data (tx1_data),
        .tx0_rd   (tx0_rd),
        .tx1_rd   (tx1_rd),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .done0    (done0),
        .done1    (done1),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_id    (rx_id),
        .sck      (sck),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso)
    );

    initial forever #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // Slave model and bus monitor, sampled mid-cycle.
    logic [2:0] k = 3'd0;
    logic [7:0] mcap = 8'd0;
    logic [7:0] cur;
    logic       prd0 = 1'b0, prd1 = 1'b0, psck = 1'b0, pcs = 1'b1;
    logic       armed = 1'b0;
    int         lowcnt = 0, hicnt = 0, viol = 0;
    int         rdc0 = 0, rdc1 = 0, dn0 = 0, dn1 = 0;
    logic [7:0] moq [$];
    logic [8:0] rxq [$];
    logic       gq [$];
    int         lowq [$];
    int         highq [$];

    initial begin
        for (int i = 0; i < 16; i++) begin
            txa0[i] = 8'd0;
            txa1[i] = 8'd0;
            mba[i]  = 8'd0;
        end
        forever begin
            @(negedge clk);
            if (prd0) i0 = i0 + 4'd1;
            if (prd1) i1 = i1 + 4'd1;
            prd0 = tx0_rd;
            prd1 = tx1_rd;
            if (cs_n === 1'b1) begin
                k = 3'd0;
            end else if (sck && !psck) begin
                mcap = {mcap[6:0], mosi};
                k = k + 3'd1;
                if (k == 3'd0) begin
                    moq.push_back(mcap);
                    mi = mi + 4'd1;
                end
            end
            cur = mba[mi];
            sl_bit = cur[3'd7 - k];
            if (cs_n === 1'b0 && pcs) begin
                if (armed) highq.push_back(hicnt);
                gq.push_back(gnt1);
                if (gnt0 == gnt1) viol++;
                hicnt = 0;
            end
            if (cs_n === 1'b1 && !pcs) begin
                lowq.push_back(lowcnt);
                lowcnt = 0;
            end
            if (cs_n === 1'b1) hicnt++;
            else if (cs_n === 1'b0) begin
                lowcnt++;
                armed = 1'b1;
            end
            if ((gnt0 | gnt1) === cs_n) viol++;
            if (gnt0 && gnt1) viol++;
            if (cs_n === 1'b1 && (sck || mosi)) viol++;
            if (rx_valid) rxq.push_back({rx_id, rx_data});
            if (tx0_rd) rdc0++;
            if (tx1_rd) rdc1++;
            if (done0) dn0++;
            if (done1) dn1++;
            psck = sck;
            pcs  = (cs_n !== 1'b0);
        end
    end

    task automatic clear_mon();
        moq.delete();
        rxq.delete();
        gq.delete();
        lowq.delete();
        highq.delete();
        viol = 0;
        rdc0 = 0;
        rdc1 = 0;
        dn0 = 0;
        dn1 = 0;
        armed = 1'b0;
        mi = 4'd0;
        i0 = 4'd0;
        i1 = 4'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One transaction; expected bytes follow from the loopback/slave setup.
    task automatic do_txn(input string tag, input logic lane,
                          input logic [3:0] len, input logic lp,
                          input logic [7:0] base, input logic [7:0] mb,
                          input logic [7:0] mstep, input int exp_low);
        int n;
        int cyc;
        logic [7:0] tb_b;
        logic [7:0] ex;
        n = int'(len) + 1;
        @(negedge clk);
        clear_mon();
        lpbk = lp;
        for (int i = 0; i < 16; i++) begin
            tb_b = base + 8'(i);
            if (lane) txa1[i] = tb_b;
            else txa0[i] = tb_b;
            mba[i] = mb + 8'(i * int'(mstep));
        end
        if (lane) begin
            len1 = len;
            req1 = 1'b1;
        end else begin
            len0 = len;
            req0 = 1'b1;
        end
        cyc = 0;
        while (!(gnt0 || gnt1) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " gnt_wait"}, int'(gnt0 || gnt1), 1);
        req0 = 1'b0;
        req1 = 1'b0;
        cyc = 0;
        while (dn0 + dn1 == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " done_wait"}, int'(dn0 + dn1 > 0), 1);
        repeat (CS_GAP + 3) @(negedge clk);
        chk({tag, " gnt_lane"}, gq.size() > 0 ? int'(gq[0]) : -1, int'(lane));
        chk({tag, " cs_low"}, lowq.size() > 0 ? lowq[0] : -1, exp_low);
        chk({tag, " done_own"}, lane ? dn1 : dn0, 1);
        chk({tag, " done_other"}, lane ? dn0 : dn1, 0);
        chk({tag, " rd_cnt"}, lane ? rdc1 : rdc0, n);
        chk({tag, " rx_cnt"}, rxq.size(), n);
        chk({tag, " mosi_cnt"}, moq.size(), n);
        for (int i = 0; i < n; i++) begin
            tb_b = base + 8'(i);
            ex = lp ? tb_b : mba[i];
            if (i < rxq.size()) begin
                chk($sformatf("%s rx_byte%0d", tag, i), int'(rxq[i][7:0]), int'(ex));
                chk($sformatf("%s rx_id%0d", tag, i), int'(rxq[i][8]), int'(lane));
            end
            if (i < moq.size()) begin
                chk($sformatf("%s mosi_byte%0d", tag, i), int'(moq[i]), int'(tb_b));
            end
        end
        chk({tag, " bus_rules"}, viol, 0);
    endtask

    typedef struct {
        logic       lane;
        logic [3:0] len;
        logic       lp;
        logic [7:0] base;
        logic [7:0] mb;
        int         exp_low;
    } vec_t;

    vec_t tbl [5];
    logic exp_ord [4];

    initial begin
        int cyc;
        logic       r_lane;
        logic [3:0] r_len;
        logic       r_lp;
        int         r_low;

        tbl[0] = '{1'b0, 4'd0,  1'b1, 8'hA5, 8'h00, 36};
        tbl[1] = '{1'b1, 4'd2,  1'b0, 8'h01, 8'h3C, 100};
        tbl[2] = '{1'b0, 4'd1,  1'b0, 8'hF0, 8'h81, 68};
        tbl[3] = '{1'b1, 4'd15, 1'b1, 8'h10, 8'h00, 516};
        tbl[4] = '{1'b0, 4'd15, 1'b0, 8'hC3, 8'h5A, 516};
`ifdef ETH_SPI_RR_EN
        exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_ord = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst sck", int'(sck), 0);
        chk("rst cs_n", int'(cs_n), 1);
        chk("rst mosi", int'(mosi), 0);
        chk("rst gnt", int'({gnt1, gnt0}), 0);
        chk("rst rd", int'({tx1_rd, tx0_rd}), 0);
        chk("rst done", int'({done1, done0}), 0);
        chk("rst rx_valid", int'(rx_valid), 0);
        chk("rst rx_data", int'(rx_data), 0);
        chk("rst rx_id", int'(rx_id), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            do_txn($sformatf("vec%0d", v), tbl[v].lane, tbl[v].len, tbl[v].lp,
                   tbl[v].base, tbl[v].mb, 8'd0, tbl[v].exp_low);
        end

        // Reset during bit 3, then a clean transaction
        @(negedge clk);
        clear_mon();
        lpbk = 1'b1;
        txa0[0] = 8'hA5;
        len0 = 4'd0;
        req0 = 1'b1;
        cyc = 0;
        while (!gnt0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        req0 = 1'b0;
        cyc = 0;
        while (k != 3'd5 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("kill bit3_wait", int'(k), 5);
        rst = 1'b1;
        @(negedge clk);
        chk("kill cs_n", int'(cs_n), 1);
        chk("kill sck", int'(sck), 0);
        chk("kill gnt0", int'(gnt0), 0);
        chk("kill mosi", int'(mosi), 0);
        chk("kill done0", int'(done0), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("kill no_done", dn0 + dn1, 0);
        do_txn("after_kill", 1'b0, 4'd0, 1'b1, 8'hA5, 8'h00, 8'd0, 36);

        // Tie with both requests held; also checks the inter-transaction gap
        do_reset();
        clear_mon();
        lpbk = 1'b1;
        len0 = 4'd0;
        len1 = 4'd0;
        req0 = 1'b1;
        req1 = 1'b1;
        cyc = 0;
        while (dn0 + dn1 < 4 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (CS_GAP + 4) @(negedge clk);
        chk("tie grants", gq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tie order%0d", i),
                i < gq.size() ? int'(gq[i]) : -1, int'(exp_ord[i]));
        end
        chk("tie gap_cnt", highq.size(), 3);
        for (int i = 0; i < highq.size(); i++) begin
            chk($sformatf("tie gap%0d", i), highq[i], CS_GAP + 1);
        end
        chk("tie bus_rules", viol, 0);

        // Random transactions against the transaction-level model
        for (int t = 0; t < 12; t++) begin
            r_lane = 1'($urandom_range(0, 1));
            r_len  = 4'($urandom_range(0, 3));
            r_lp   = 1'($urandom_range(0, 1));
            r_low  = CS_SETUP + (int'(r_len) + 1) * 8 * 2 * CLK_DIV + CS_HOLD;
            do_txn($sformatf("rnd%0d", t), r_lane, r_len, r_lp,
                   8'($urandom), 8'($urandom), 8'($urandom), r_low);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
